// File: rtl/sd_init_sequencer_if.sv
// Command/response channel between the SD init sequencer and the CMD-line PHY.
//   cmd_valid/cmd_ready : command handshake (sequencer -> PHY)
//   cmd_index, cmd_arg  : command being issued, stable while cmd_valid is high
//   resp_valid          : PHY delivered a response (one cycle)
//   resp_err            : that response failed CRC or framing
//   resp_arg            : response payload (R1/R3/R6/R7 body)
interface sd_init_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_arg;

  modport master (
    output cmd_valid, cmd_index, cmd_arg,
    input  cmd_ready, resp_valid, resp_err, resp_arg
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg,
    output cmd_ready, resp_valid, resp_err, resp_arg
  );
endinterface

// File: rtl/sd_init_sequencer.sv
// SD card identification sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD2,
// CMD3, CMD7, leaving the card in Transfer state.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : one-cycle pulse, ignored while busy
//   bus         : command/response channel to the PHY (master side)
//   busy, done  : sequence in progress / one-cycle success pulse
//   fail        : sticky failure, cause in fail_code
//                 (1 bad CMD8 echo, 2 ACMD41 poll limit, 3 voltage mismatch,
//                  4 resend limit)
//   card_state  : 0 INACTIVE, 1 IDLE, 2 READY, 3 IDENT, 4 STANDBY, 5 TRANSFER
//   rca, ocr, ccs : published card address, last OCR, high-capacity flag
module sd_init_sequencer #(
  parameter int          ACMD41_RETRIES = 1000,
  parameter int          CMD_RETRIES    = 3,
  parameter int          RESP_TIMEOUT   = 64,
  parameter int          POLL_GAP       = 256,
  parameter logic [23:0] VOLT_WINDOW    = 24'hFF8000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  sd_init_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [2:0]          fail_code,
  output logic [3:0]          card_state,
  output logic [15:0]         rca,
  output logic [31:0]         ocr,
  output logic                ccs
);
  localparam int TW = $clog2(RESP_TIMEOUT + 2);
  localparam int GW = $clog2(POLL_GAP + 2);
  localparam int PW = $clog2(ACMD41_RETRIES + 2);
  localparam int AW = $clog2(CMD_RETRIES + 2);
  localparam logic [TW-1:0] T_LAST = TW'(RESP_TIMEOUT);
  localparam logic [GW-1:0] G_LAST = GW'(POLL_GAP);
  localparam logic [PW-1:0] P_LAST = PW'(ACMD41_RETRIES - 1);
  localparam logic [AW-1:0] A_LAST = AW'(CMD_RETRIES);

  localparam logic [3:0] CS_INACTIVE = 4'd0, CS_IDLE = 4'd1, CS_READY = 4'd2,
                         CS_IDENT = 4'd3, CS_STANDBY = 4'd4, CS_TRANSFER = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;
  typedef enum logic [2:0] {P_CMD0, P_CMD8, P_CMD55, P_ACMD41,
                            P_CMD2, P_CMD3, P_CMD7} phase_t;

  state_t state, state_n;
  phase_t phase, phase_n;

  logic [TW-1:0] t_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic [AW-1:0] att_cnt;
  logic          hcs;

  logic       resend, fail_now, att_clr, set_hcs, set_ready, poll_inc;
  logic       set_ident, set_rca, set_xfer, ocr_ld;
  logic [2:0] code_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= P_CMD0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    resend    = 1'b0;
    fail_now  = 1'b0;
    code_n    = 3'd0;
    att_clr   = 1'b0;
    set_hcs   = 1'b0;
    set_ready = 1'b0;
    poll_inc  = 1'b0;
    set_ident = 1'b0;
    set_rca   = 1'b0;
    set_xfer  = 1'b0;
    ocr_ld    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_SEND;
        phase_n = P_CMD0;
      end
      S_SEND: if (bus.cmd_ready) state_n = S_WAIT;
      S_WAIT: begin
        if (phase == P_CMD0) begin
          // CMD0 has no response: one idle cycle, then CMD8
          state_n = S_SEND;
          phase_n = P_CMD8;
        end else if (bus.resp_valid) begin
          if (bus.resp_err) begin
            resend = 1'b1;
          end else begin
            att_clr = 1'b1;
            state_n = S_SEND;
            case (phase)
              P_CMD8: begin
                if (bus.resp_arg[11:0] == 12'h1AA) begin
                  set_hcs = 1'b1;
                  phase_n = P_CMD55;
                end else begin
                  fail_now = 1'b1;
                  code_n   = 3'd1;
                end
              end
              P_CMD55: phase_n = P_ACMD41;
              P_ACMD41: begin
                ocr_ld = 1'b1;
                if ((bus.resp_arg[23:0] & VOLT_WINDOW) == 24'h0) begin
                  fail_now = 1'b1;
                  code_n   = 3'd3;
                end else if (!bus.resp_arg[31]) begin
                  if (poll_cnt == P_LAST) begin
                    fail_now = 1'b1;
                    code_n   = 3'd2;
                  end else begin
                    poll_inc = 1'b1;
                    state_n  = S_GAP;
                    phase_n  = P_CMD55;
                  end
                end else begin
                  set_ready = 1'b1;
                  phase_n   = P_CMD2;
                end
              end
              P_CMD2: begin
                set_ident = 1'b1;
                phase_n   = P_CMD3;
              end
              P_CMD3: begin
                // a zero RCA is unusable; reissue, spending a resend attempt
                if (bus.resp_arg[31:16] == 16'h0) begin
                  att_clr = 1'b0;
                  resend  = 1'b1;
                end else begin
                  set_rca = 1'b1;
                  phase_n = P_CMD7;
                end
              end
              P_CMD7: begin
                set_xfer = 1'b1;
                state_n  = S_IDLE;
              end
              default: ;
            endcase
          end
        end else if (t_cnt == T_LAST) begin
          // a silent CMD8 marks a v1 card rather than an error
          if (phase == P_CMD8) begin
            att_clr = 1'b1;
            state_n = S_SEND;
            phase_n = P_CMD55;
          end else begin
            resend = 1'b1;
          end
        end
      end
      S_GAP: if (gap_cnt == G_LAST) state_n = S_SEND;
      default: state_n = S_IDLE;
    endcase
    if (resend) begin
      if (att_cnt == A_LAST) begin
        fail_now = 1'b1;
        code_n   = 3'd4;
      end else begin
        state_n = S_SEND;
      end
    end
    if (fail_now) state_n = S_IDLE;
  end

  assign bus.cmd_valid = (state == S_SEND);

  always_comb begin
    bus.cmd_index = 6'd0;
    bus.cmd_arg   = 32'h0;
    if (state == S_SEND) begin
      case (phase)
        P_CMD8:   begin bus.cmd_index = 6'd8;  bus.cmd_arg = 32'h0000_01AA; end
        P_CMD55:  bus.cmd_index = 6'd55;
        P_ACMD41: begin bus.cmd_index = 6'd41; bus.cmd_arg = {1'b0, hcs, 6'b0, VOLT_WINDOW}; end
        P_CMD2:   bus.cmd_index = 6'd2;
        P_CMD3:   bus.cmd_index = 6'd3;
        P_CMD7:   begin bus.cmd_index = 6'd7;  bus.cmd_arg = {rca, 16'h0}; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= 3'd0;
      card_state <= CS_IDLE;
      rca        <= 16'h0;
      ocr        <= 32'h0;
      ccs        <= 1'b0;
      hcs        <= 1'b0;
      t_cnt      <= '0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
      att_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        busy      <= 1'b1;
        fail      <= 1'b0;
        fail_code <= 3'd0;
        rca       <= 16'h0;
        ocr       <= 32'h0;
        ccs       <= 1'b0;
        hcs       <= 1'b0;
        poll_cnt  <= '0;
        att_cnt   <= '0;
      end
      // timeout count is 1 in the first cycle after acceptance
      if (state == S_SEND && bus.cmd_ready) begin
        t_cnt <= TW'(1);
        if (phase == P_CMD0) card_state <= CS_IDLE;
      end else if (state == S_WAIT) begin
        t_cnt <= t_cnt + 1'b1;
      end
      if (poll_inc) gap_cnt <= GW'(1);
      else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      if (poll_inc) poll_cnt <= poll_cnt + 1'b1;
      if (resend && !fail_now) att_cnt <= att_cnt + 1'b1;
      else if (att_clr) att_cnt <= '0;
      if (set_hcs) hcs <= 1'b1;
      if (ocr_ld) ocr <= bus.resp_arg;
      if (set_ready) begin
        ccs        <= bus.resp_arg[30] & hcs;
        card_state <= CS_READY;
      end
      if (set_ident) card_state <= CS_IDENT;
      if (set_rca) begin
        rca        <= bus.resp_arg[31:16];
        card_state <= CS_STANDBY;
      end
      if (set_xfer) begin
        card_state <= CS_TRANSFER;
        done       <= 1'b1;
        busy       <= 1'b0;
      end
      if (fail_now) begin
        card_state <= CS_INACTIVE;
        fail       <= 1'b1;
        fail_code  <= code_n;
        busy       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed, table-driven bench for sd_init_sequencer acting as the PHY.
module tb_sd_init_sequencer;
  localparam int RT = 8;
  localparam int PG = 5;
  localparam logic [31:0] A41_H = 32'h40FF8000;
  localparam logic [31:0] A41_L = 32'h00FF8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, fail, ccs;
  logic [2:0]  fail_code;
  logic [3:0]  card_state;
  logic [15:0] rca;
  logic [31:0] ocr;

  sd_init_sequencer_if bus();

  sd_init_sequencer #(
    .ACMD41_RETRIES(4), .CMD_RETRIES(3), .RESP_TIMEOUT(RT), .POLL_GAP(PG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .fail(fail), .fail_code(fail_code),
    .card_state(card_state), .rca(rca), .ocr(ocr), .ccs(ccs)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_NONE, K_OK, K_ERR} kind_t;
  typedef struct {
    int          sc;
    logic [5:0]  idx;
    logic [31:0] arg;
    kind_t       kind;
    logic [31:0] rarg;
    int          wt;    // negedges waited for this command after the previous step
    logic [3:0]  cs;    // card_state after the step
    int          hold;  // cycles cmd_ready is withheld
  } step_t;

  step_t tbl[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(int sc, logic [5:0] idx, logic [31:0] arg, kind_t k,
                              logic [31:0] rarg, int wt, logic [3:0] cs, int hold = 0);
    step_t s;
    s.sc = sc; s.idx = idx; s.arg = arg; s.kind = k; s.rarg = rarg;
    s.wt = wt; s.cs = cs; s.hold = hold;
    tbl.push_back(s);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_fail"}, fail, 0);
    chk({p, "_code"}, fail_code, 0);
    chk({p, "_state"}, card_state, 1);
    chk({p, "_rca"}, rca, 0);
    chk({p, "_ocr"}, ocr, 0);
    chk({p, "_ccs"}, ccs, 0);
    chk({p, "_valid"}, bus.cmd_valid, 0);
    chk({p, "_index"}, bus.cmd_index, 0);
    chk({p, "_arg"}, bus.cmd_arg, 0);
  endtask

  task automatic do_step(input step_t s);
    int n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL cmd_wait: got no command, want index %0d", s.idx);
      return;
    end
    chk($sformatf("sc%0d_wait_cmd%0d", s.sc, s.idx), n, s.wt);
    chk($sformatf("sc%0d_index", s.sc), bus.cmd_index, s.idx);
    chk($sformatf("sc%0d_arg_cmd%0d", s.sc, s.idx), bus.cmd_arg, s.arg);
    if (s.hold > 0) begin
      repeat (s.hold) @(negedge clk);
      chk("hold_valid", bus.cmd_valid, 1);
      chk("hold_index", bus.cmd_index, s.idx);
      chk("hold_arg", bus.cmd_arg, s.arg);
    end
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    chk($sformatf("sc%0d_valid_drop_cmd%0d", s.sc, s.idx), bus.cmd_valid, 0);
    if (s.kind != K_NONE) begin
      @(negedge clk);
      bus.resp_valid = 1'b1;
      bus.resp_err   = (s.kind == K_ERR);
      bus.resp_arg   = s.rarg;
      @(negedge clk);
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.resp_arg   = 32'h0;
    end
    chk($sformatf("sc%0d_state_cmd%0d", s.sc, s.idx), card_state, s.cs);
  endtask

  task automatic run_sc(input int sc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("sc%0d_start_busy", sc), busy, 1);
    chk($sformatf("sc%0d_start_fail", sc), fail, 0);
    chk($sformatf("sc%0d_start_code", sc), fail_code, 0);
    foreach (tbl[i]) if (tbl[i].sc == sc) do_step(tbl[i]);
  endtask

  task automatic no_cmd(input string nm);
    logic seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.cmd_valid === 1'b1) seen = 1'b1;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    int d0;
    bus.cmd_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_arg   = 32'h0;

    // 1: v2 card happy path, CMD0 held off for three cycles
    add(1, 0, 0, K_NONE, 0, 0, 1, 3);
    add(1, 8, 32'h1AA, K_OK, 32'h1AA, 1, 1);
    add(1, 55, 0, K_OK, 32'h120, 0, 1);
    add(1, 41, A41_H, K_OK, 32'h00FF8000, 0, 1);
    add(1, 55, 0, K_OK, 32'h120, PG, 1);
    add(1, 41, A41_H, K_OK, 32'h00FF8000, 0, 1);
    add(1, 55, 0, K_OK, 32'h120, PG, 1);
    add(1, 41, A41_H, K_OK, 32'hC0FF8000, 0, 2);
    add(1, 2, 0, K_OK, 0, 0, 3);
    add(1, 3, 0, K_OK, 32'h12340000, 0, 4);
    add(1, 7, 32'h12340000, K_OK, 32'h900, 0, 5);
    // 2: v1 card (silent CMD8), CMD3 first returns a zero RCA
    add(2, 0, 0, K_NONE, 0, 0, 1);
    add(2, 8, 32'h1AA, K_NONE, 0, 1, 1);
    add(2, 55, 0, K_OK, 32'h120, RT, 1);
    add(2, 41, A41_L, K_OK, 32'hC0FF8000, 0, 2);
    add(2, 2, 0, K_OK, 0, 0, 3);
    add(2, 3, 0, K_OK, 32'h0000FFFF, 0, 3);
    add(2, 3, 0, K_OK, 32'h00010000, 0, 4);
    add(2, 7, 32'h00010000, K_OK, 0, 0, 5);
    // 3: ACMD41 busy forever, limit 4
    add(3, 0, 0, K_NONE, 0, 0, 1);
    add(3, 8, 32'h1AA, K_OK, 32'h1AA, 1, 1);
    add(3, 55, 0, K_OK, 0, 0, 1);
    add(3, 41, A41_H, K_OK, 32'h00FF8000, 0, 1);
    add(3, 55, 0, K_OK, 0, PG, 1);
    add(3, 41, A41_H, K_OK, 32'h00FF8000, 0, 1);
    add(3, 55, 0, K_OK, 0, PG, 1);
    add(3, 41, A41_H, K_OK, 32'h00FF8000, 0, 1);
    add(3, 55, 0, K_OK, 0, PG, 1);
    add(3, 41, A41_H, K_OK, 32'h00FF8000, 0, 0);
    // 4: bad CMD8 echo
    add(4, 0, 0, K_NONE, 0, 0, 1);
    add(4, 8, 32'h1AA, K_OK, 32'h1AB, 1, 0);
    // 5: CMD2 response error four times
    add(5, 0, 0, K_NONE, 0, 0, 1);
    add(5, 8, 32'h1AA, K_OK, 32'h1AA, 1, 1);
    add(5, 55, 0, K_OK, 0, 0, 1);
    add(5, 41, A41_H, K_OK, 32'hC0FF8000, 0, 2);
    add(5, 2, 0, K_ERR, 0, 0, 2);
    add(5, 2, 0, K_ERR, 0, 0, 2);
    add(5, 2, 0, K_ERR, 0, 0, 2);
    add(5, 2, 0, K_ERR, 0, 0, 0);
    // 6: OCR outside the voltage window
    add(6, 0, 0, K_NONE, 0, 0, 1);
    add(6, 8, 32'h1AA, K_OK, 32'h1AA, 1, 1);
    add(6, 55, 0, K_OK, 0, 0, 1);
    add(6, 41, A41_H, K_OK, 32'h80000000, 0, 0);
    // 7: lead-in to a reset during the poll gap
    add(7, 0, 0, K_NONE, 0, 0, 1);
    add(7, 8, 32'h1AA, K_OK, 32'h1AA, 1, 1);
    add(7, 55, 0, K_OK, 0, 0, 1);
    add(7, 41, A41_H, K_OK, 32'h00FF8000, 0, 1);

    repeat (3) @(negedge clk);
    chk_reset_vals("rst_held");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_rel");

    d0 = done_cnt;
    run_sc(1);
    chk("sc1_done", done, 1);
    chk("sc1_busy", busy, 0);
    chk("sc1_ccs", ccs, 1);
    chk("sc1_rca", rca, 16'h1234);
    chk("sc1_ocr", ocr, 32'hC0FF8000);
    chk("sc1_fail", fail, 0);
    repeat (3) @(negedge clk);
    chk("sc1_done_once", done_cnt - d0, 1);

    run_sc(2);
    chk("sc2_ccs", ccs, 0);
    chk("sc2_rca", rca, 16'h0001);
    chk("sc2_done", done, 1);

    run_sc(3);
    chk("sc3_fail", fail, 1);
    chk("sc3_code", fail_code, 2);
    chk("sc3_busy", busy, 0);
    no_cmd("sc3_no_cmd");
    chk("sc3_fail_sticky", fail, 1);

    run_sc(4);
    chk("sc4_fail", fail, 1);
    chk("sc4_code", fail_code, 1);
    no_cmd("sc4_no_cmd55");

    run_sc(5);
    chk("sc5_fail", fail, 1);
    chk("sc5_code", fail_code, 4);
    no_cmd("sc5_no_cmd");

    run_sc(6);
    chk("sc6_code", fail_code, 3);
    chk("sc6_ocr", ocr, 32'h80000000);
    chk("sc6_state", card_state, 0);

    run_sc(7);
    // now inside the poll gap: a start pulse must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sc7_ign_busy", busy, 1);
    chk("sc7_ign_ocr", ocr, 32'h00FF8000);
    chk("sc7_ign_state", card_state, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("sc7_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("sc7_rel");
    no_cmd("sc7_no_cmd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
